fetch_unit: RTL and testbench

- Decoupled instruction-fetch front end that feeds the core's decode stage.
- Issues sequential 4-byte fetch requests to a variable-latency instruction memory and buffers returned words with their PCs in a small prefetch queue.
- Presents the buffered words to decode over a valid/ready handshake.
- Accepts branch redirects from execute; a redirect flushes the queue and discards in-flight responses.

---
 rtl/olivia_pkg.sv | 18 +
 rtl/fetch_queue.sv | 54 +++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/olivia_pkg.sv
// Shared fetch-path types, widths and helpers.
// Used by fetch_unit and fetch_queue.
package olivia_pkg;

  localparam int ADDR_W  = 64;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries: push, pop, flush, count.
// Ports: clk, rst(n), push_i/data_i, pop_i, flush_i, head_o, count_o.
module fetch_queue #(
  parameter int  DEPTH = 4,
  parameter type T     = olivia_pkg::fetch_entry_t,
  parameter int  CW    = olivia_pkg::cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output T              head_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          pop;

  assign pop     = pop_i && (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch front end: credit-limited imem requests,
// prefetch queue to decode, redirect flush with stale drop.
module fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  import olivia_pkg::*;

  localparam int CW = cnt_w(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic              run_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     count;
  logic [CW:0]       used;
  logic              req_fire;
  logic              drop_now;
  logic              push;
  entry_t            wr_ent;
  entry_t            head;

  // Stale in-flight requests keep holding credit until they return.
  assign used           = {1'b0, outst_q} + {1'b0, count};
  assign imem_req_valid = run_q && (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign drop_now = imem_resp_valid && (drop_q != '0);
  assign push     = imem_resp_valid && !drop_now;

  assign wr_ent.pc   = resp_pc_q;
  assign wr_ent.inst = imem_resp_data;

  assign inst_valid = (count != '0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  always_comb begin
    outst_d    = outst_q + CW'(req_fire)
                         - CW'(imem_resp_valid);
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    unique case (1'b1)
      redirect_valid: begin
        fetch_pc_d = redirect_pc;
        resp_pc_d  = redirect_pc;
        drop_d     = outst_d;
      end
      default: begin
        if (req_fire) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
        end
        if (push) begin
          resp_pc_d = resp_pc_q + ADDR_W'(PC_STEP);
        end
        if (drop_now) begin
          drop_d = drop_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .T     (entry_t),
    .CW    (CW)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (wr_ent),
    .pop_i   (inst_ready),
    .flush_i (redirect_valid),
    .head_o  (head),
    .count_o (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order,
// fixed-latency instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct {
    logic [63:0] a;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [63:0] req_log[$];
  logic [63:0] seen[$];
  logic        fire_p = 1'b0;
  logic [63:0] fire_a = '0;
  int          ms, mr;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] at(input logic [63:0] q[$],
                                     input int i);
    if (i < 0 || i >= q.size()) return 64'hBAD0_BAD0_BAD0_BAD0;
    return q[i];
  endfunction

  // Memory model and pop monitor, all on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      pend.delete();
      imem_resp_valid = 1'b0;
      fire_p = 1'b0;
    end else begin
      if (imem_resp_valid) void'(pend.pop_front());
      if (fire_p) pend.push_back('{fire_a, cyc + lat});
      imem_resp_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = ~pend[0].a[31:0];
      end
      fire_p = imem_req_valid & imem_req_ready;
      fire_a = imem_req_addr;
      if (fire_p) req_log.push_back(imem_req_addr);
      if (inst_valid && inst_ready) begin
        seen.push_back(inst_pc);
        check("word", {32'h0, inst}, {32'h0, ~inst_pc[31:0]});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset;
    rst = 1'b0;
    redirect_valid = 1'b0;
    tick(2);
    req_log.delete();
    seen.delete();
    rst = 1'b1;
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
    ms = seen.size();
    mr = req_log.size();
  endtask

  initial begin
    // reset state, streaming at one word per cycle
    tick(2);
    check("rst_reqv", imem_req_valid, 0);
    check("rst_instv", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);
    do_reset();
    tick();
    check("t1_reqv", imem_req_valid, 1);
    check("t1_addr0", imem_req_addr, 64'h0);
    tick();
    check("t1_addr4", imem_req_addr, 64'h4);
    check("t1_noval", inst_valid, 0);
    tick();
    check("t1_val", inst_valid, 1);
    check("t1_pc0", inst_pc, 64'h0);
    tick();
    check("t1_pc4", inst_pc, 64'h4);
    tick();
    check("t1_pc8", inst_pc, 64'h8);

    // full queue: credit cap then drain
    inst_ready = 1'b0;
    do_reset();
    tick(10);
    check("t2_nreq", req_log.size(), 4);
    check("t2_last", at(req_log, 3), 64'hC);
    check("t2_reqv", imem_req_valid, 0);
    check("t2_head", inst_pc, 64'h0);
    inst_ready = 1'b1;
    tick();
    check("t2_resv", imem_req_valid, 1);
    check("t2_res10", imem_req_addr, 64'h10);
    tick(6);
    for (int k = 0; k < 4; k++)
      check("t2_drain", at(seen, k), 64'(4 * k));

    // latency 3, three in flight, redirect drops them
    lat = 3;
    do_reset();
    tick(4);
    check("t3_fpc", imem_req_addr, 64'hC);
    imem_req_ready = 1'b0;
    redirect(64'h1000);
    imem_req_ready = 1'b1;
    check("t3_reqv", imem_req_valid, 1);
    check("t3_addr", imem_req_addr, 64'h1000);
    check("t3_noval", inst_valid, 0);
    tick(8);
    check("t3_first", at(seen, 0), 64'h1000);
    check("t3_next", at(seen, 1), 64'h1004);

    // redirect with response and request firing that cycle
    lat = 1;
    do_reset();
    tick(8);
    redirect(64'h2000);
    tick(8);
    check("t4_req", at(req_log, mr), 64'h2000);
    for (int k = 0; k < 4; k++)
      check("t4_seq", at(seen, ms + k), 64'h2000 + 64'(4 * k));

    // address wrap
    do_reset();
    tick(4);
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    tick(8);
    check("t5_req0", at(req_log, mr), 64'hFFFF_FFFF_FFFF_FFFC);
    check("t5_req1", at(req_log, mr + 1), 64'h0);
    check("t5_pc0", at(seen, ms), 64'hFFFF_FFFF_FFFF_FFFC);
    check("t5_pc1", at(seen, ms + 1), 64'h0);

    // asynchronous reset between edges
    do_reset();
    tick(6);
    check("t6_pre", inst_valid, 1);
    #1 rst = 1'b0;
    #1;
    check("t6_instv", inst_valid, 0);
    check("t6_reqv", imem_req_valid, 0);
    tick(2);
    req_log.delete();
    seen.delete();
    rst = 1'b1;
    tick();
    check("t6_reqv2", imem_req_valid, 1);
    check("t6_addr", imem_req_addr, 64'h0);
    tick(5);
    check("t6_first", at(seen, 0), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
